dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//  Sequences the direct-mapped data cache for NUM_REQ requesters (round-robin).
//  Performs lookup, read-miss fetch/fill from backing memory, write-through on stores.
//  Sits between core-side load/store ports and the cache array plus memory bus.
//  The cache array is an external block; this controller only drives its ports.
// PARAMETERS
//  NUM_REQ  2  number of requester ports (>=1)
//  ADDR_W   9  byte address width
//  DATA_W   8  data word width
// PORTS
//  clk        in   1                clock
//  reset      in   1                synchronous, active-high reset
//  req_valid  in   NUM_REQ          per-requester request valid
//  req_we     in   NUM_REQ          1=store, 0=load
//  req_addr   in   NUM_REQ*ADDR_W   packed per-requester address
//  req_wdata  in   NUM_REQ*DATA_W   packed per-requester store data
//  req_ready  out  NUM_REQ          accept pulse; at most one bit set
//  rsp_valid  out  NUM_REQ          completion pulse to the granted requester
//  rsp_rdata  out  DATA_W           load data; valid with rsp_valid
//  lk_valid   out  1                cache lookup strobe
//  lk_addr    out  ADDR_W           lookup address
//  lk_hit     in   1                lookup result, one cycle after lk_valid
//  lk_rdata   in   DATA_W           hit data, one cycle after lk_valid
//  fill_en    out  1                cache write strobe; sets tag and data
//  fill_addr  out  ADDR_W           cache write address
//  fill_data  out  DATA_W           cache write data
//  mem_req    out  1                memory request; held until mem_ack
//  mem_we     out  1                memory write
//  mem_addr   out  ADDR_W           memory address
//  mem_wdata  out  DATA_W           memory write data
//  mem_ack    in   1                memory done; mem_rdata valid this cycle on reads
//  mem_rdata  in   DATA_W           memory read data
// BEHAVIOUR
//  Reset:
//   - All outputs are 0; FSM goes to IDLE; round-robin pointer goes to 0.
//   - Reset mid-operation abandons the transaction with no rsp_valid.
//   - mem_req drops in the cycle after reset is sampled.
//  IDLE:
//   - Grant the first valid requester at or after the rr pointer.
//   - In the same cycle: req_ready[g]=1, lk_valid=1, lk_addr=req_addr[g].
//   - Latch g, we, addr and wdata; go to LOOKUP.
//  LOOKUP (lk_hit and lk_rdata sampled):
//   - Load hit: latch lk_rdata; go to RESP.
//   - Load miss: go to MEM_RD.
//   - Store hit: fill_en=1 with the store data this cycle; go to MEM_WR.
//   - Store miss: no allocate; go to MEM_WR.
//  MEM_RD:
//   - mem_req=1, mem_we=0, mem_addr=addr.
//   - On mem_ack: latch mem_rdata; go to FILL.
//  FILL: fill_en=1 with fill_addr=addr and fill_data=latched data; go to RESP.
//  MEM_WR:
//   - mem_req=1, mem_we=1, mem_wdata=wdata.
//   - On mem_ack: go to RESP.
//  RESP:
//   - rsp_valid[g]=1 for one cycle; rsp_rdata=latched data on loads, 0 on stores.
//   - rr pointer <= (g+1) mod NUM_REQ; go to IDLE.
//  Handshake and timing:
//   - Only one transaction in flight; req_ready is 0 outside IDLE.
//   - Requesters hold req_* until req_ready.
//   - mem_ack is ignored when mem_req=0.
//   - mem_addr, mem_we and mem_wdata are stable while mem_req=1.
//   - mem_ack in the first request cycle is legal.
//   - Latency from accept to rsp_valid: load hit 2 cycles; load miss 3+W; store 2+W.
//     W = cycles that mem_req is high.
//   - New requests arriving during a busy period wait.
//   - Simultaneous requests are arbitrated only in IDLE.
// CONFIGURATION
//  DCACHE_CTRL_STATS_EN
//   - Defined: adds output ports hit_cnt[15:0] and miss_cnt[15:0].
//   - Each counter increments once per LOOKUP (hit or miss), saturates at 16'hFFFF,
//     and clears on reset.
//   - Undefined: these ports and their logic are absent.
// STRUCTURE
//  dcache_pkg:
//   - state_t enum {IDLE,LOOKUP,MEM_RD,FILL,MEM_WR,RESP}.
//   - Default ADDR_W and DATA_W localparams.
//  Sub-module dcache_rr_arb:
//   - Combinational round-robin grant from req_valid and the pointer.
//   - Outputs a one-hot grant and its index.
// TESTING
//  1. Reset, then req0 load 9'h005, mem returns 8'hA5 after 3 cycles:
//     one mem read, fill_en at 9'h005, rsp_valid[0] with 8'hA5.
//  2. Repeat the load of 9'h005 with lk_hit=1, lk_rdata=8'hA5:
//     no mem_req; rsp_valid[0] exactly 2 cycles after accept.
//  3. req1 store 9'h185 with 8'h3C on a hit:
//     fill_en with 8'h3C in LOOKUP, then mem write of 8'h3C, then rsp_valid[1].
//  4. req0 and req1 both valid in the same cycle from reset:
//     req0 is served first, then req1, then req0 again while all three are held.
//  5. Assert reset while in MEM_RD:
//     mem_req is 0 next cycle, no rsp_valid, and the next request is accepted normally.
//  6. With STATS_EN defined, run 3 hits and 2 misses: hit_cnt=3, miss_cnt=2.

Source files
------------

// File: rtl/dcache_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dcache_pkg : shared types and default widths for the data-cache control  |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    MEM_RD = 3'd2,
    FILL   = 3'd3,
    MEM_WR = 3'd4,
    RESP   = 3'd5
  } state_t;

  localparam int C_ADDR_W = 9;
  localparam int C_DATA_W = 8;

endpackage
`default_nettype wire

// File: rtl/dcache_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dcache_rr_arb : combinational round-robin grant starting at ptr          |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module dcache_rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_valid
);

  // Offset i from the pointer is scanned first; j is the requester it maps to.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!grant_valid && req_valid[j] && (((int'(ptr) + i) % NUM_REQ) == j)) begin
          grant_valid = 1'b1;
          grant[j]    = 1'b1;
          grant_idx   = PTR_W'(j);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dcache_ctrl : direct-mapped D-cache sequencer, read-fill, write-through  |
// | Option      : DCACHE_CTRL_STATS_EN adds hit_cnt / miss_cnt outputs        |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = C_ADDR_W,
  parameter int DATA_W  = C_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
`ifdef DCACHE_CTRL_STATS_EN
  output logic [15:0]               hit_cnt,
  output logic [15:0]               miss_cnt,
`endif
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      lk_valid,
  output logic [ADDR_W-1:0]         lk_addr,
  input  logic                      lk_hit,
  input  logic [DATA_W-1:0]         lk_rdata,
  output logic                      fill_en,
  output logic [ADDR_W-1:0]         fill_addr,
  output logic [DATA_W-1:0]         fill_data,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_ack,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int C_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               r_state, w_next;
  logic [C_PTR_W-1:0]   r_ptr, r_gnt;
  logic                 r_we;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata, r_data;

  logic [NUM_REQ-1:0]   w_grant;
  logic [C_PTR_W-1:0]   w_grant_idx;
  logic                 w_grant_valid, w_accept;
  logic                 w_sel_we;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [DATA_W-1:0]    w_sel_wdata;

  dcache_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (C_PTR_W)
  ) u_arb (
    .req_valid   (req_valid),
    .ptr         (r_ptr),
    .grant       (w_grant),
    .grant_idx   (w_grant_idx),
    .grant_valid (w_grant_valid)
  );

  // Acceptance is suppressed during reset so every output stays quiet.
  assign w_accept = (r_state == IDLE) && w_grant_valid && !reset;

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_we    = req_we[i];
        w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    lk_valid  = 1'b0;
    lk_addr   = '0;
    fill_en   = 1'b0;
    fill_addr = '0;
    fill_data = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          req_ready = w_grant;
          lk_valid  = 1'b1;
          lk_addr   = w_sel_addr;
          w_next    = LOOKUP;
        end
      end
      LOOKUP: begin
        if (r_we) begin
          // Store hit updates the line in place; a store miss does not allocate.
          if (lk_hit) begin
            fill_en   = 1'b1;
            fill_addr = r_addr;
            fill_data = r_wdata;
          end
          w_next = MEM_WR;
        end else begin
          w_next = lk_hit ? RESP : MEM_RD;
        end
      end
      MEM_RD: begin
        mem_req  = 1'b1;
        mem_addr = r_addr;
        if (mem_ack) w_next = FILL;
      end
      FILL: begin
        fill_en   = 1'b1;
        fill_addr = r_addr;
        fill_data = r_data;
        w_next    = RESP;
      end
      MEM_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        if (mem_ack) w_next = RESP;
      end
      RESP: begin
        rsp_valid = NUM_REQ'(1) << r_gnt;
        rsp_rdata = r_we ? '0 : r_data;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_gnt   <= w_grant_idx;
        r_we    <= w_sel_we;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end
      if (r_state == LOOKUP && !r_we && lk_hit) r_data <= lk_rdata;
      if (r_state == MEM_RD && mem_ack)         r_data <= mem_rdata;
      if (r_state == RESP)
        r_ptr <= (r_gnt == C_PTR_W'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
    end
  end

`ifdef DCACHE_CTRL_STATS_EN
  logic [15:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == LOOKUP) begin
      if (lk_hit && r_hit_cnt != 16'hFFFF)    r_hit_cnt  <= r_hit_cnt + 16'd1;
      if (!lk_hit && r_miss_cnt != 16'hFFFF)  r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// Self-checking bench for dcache_ctrl: bench acts as cache array, memory and
// requesters, and predicts every cycle from transaction-level latency rules.
module tb_dcache_ctrl;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 8;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid, req_we, req_ready, rsp_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]         rsp_rdata, lk_rdata, fill_data, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0]         lk_addr, fill_addr, mem_addr;
  logic                      lk_valid, lk_hit, fill_en, mem_req, mem_we, mem_ack;
`ifdef DCACHE_CTRL_STATS_EN
  logic [15:0]               hit_cnt, miss_cnt;
`endif

  dcache_ctrl #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
`ifdef DCACHE_CTRL_STATS_EN
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_rdata(lk_rdata),
    .fill_en(fill_en), .fill_addr(fill_addr), .fill_data(fill_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // environment: backing memory and cache array contents
  logic [DATA_W-1:0] mem   [512];
  bit                cvalid[512];
  logic [DATA_W-1:0] cdata [512];

  // requesters
  bit                p_valid[NUM_REQ];
  bit                p_we   [NUM_REQ];
  logic [ADDR_W-1:0] p_addr [NUM_REQ];
  logic [DATA_W-1:0] p_wdata[NUM_REQ];

  // transaction-level model
  bit t_act, t_we, t_hit;
  int t_off, t_g, t_w, t_len, ptr;
  logic [ADDR_W-1:0] t_addr;
  logic [DATA_W-1:0] t_wdata, t_rdata;
  int m_hit, m_miss;

  bit gen_en, rst_req, prev_lk;
  logic [ADDR_W-1:0] prev_lkaddr;
  int force_w, cyc, acc_cyc;

  // observations for directed literal checks
  int mreq_cycles, rsp_count, last_rsp_lat, last_rsp_idx;
  logic [DATA_W-1:0] last_rsp_data, last_fill_data, last_mw_data;
  logic [ADDR_W-1:0] last_fill_addr;
  int grant_log[$];

  int vectors, errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit in_mem(input int off);
    return !(!t_we && t_hit) && off >= 2 && off <= 1 + t_w;
  endfunction

  task automatic cycle();
    logic [4:0] a;
    int nx, acc, gidx;
    logic [NUM_REQ-1:0] e_ready, e_rsp;
    logic e_lk, e_fill, e_mreq, e_mwe;
    logic [ADDR_W-1:0] e_lkaddr, e_faddr, e_maddr;
    logic [DATA_W-1:0] e_fdata, e_mwdata, e_rdata;
    @(negedge clk);
    reset = rst_req;
    if (gen_en)
      for (int i = 0; i < NUM_REQ; i++)
        if (!p_valid[i] && $urandom_range(0, 2) == 0) begin
          a          = 5'($urandom_range(0, 31));
          p_valid[i] = 1'b1;
          p_we[i]    = ($urandom_range(0, 2) == 0);
          p_addr[i]  = {a[4], 4'b0, a[3:0]};
          p_wdata[i] = 8'($urandom);
        end
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]                   = p_valid[i];
      req_we[i]                      = p_we[i];
      req_addr[i*ADDR_W +: ADDR_W]   = p_addr[i];
      req_wdata[i*DATA_W +: DATA_W]  = p_wdata[i];
    end
    if (prev_lk) begin
      lk_hit = cvalid[prev_lkaddr]; lk_rdata = cdata[prev_lkaddr];
    end else begin
      lk_hit = 1'($urandom_range(0, 1)); lk_rdata = 8'($urandom);
    end
    if (gen_en && $urandom_range(0, 7) == 0) begin
      a = 5'($urandom_range(0, 31));
      cvalid[{a[4], 4'b0, a[3:0]}] = 1'b0;
    end
    nx = t_act ? t_off + 1 : -1;
    if (rst_req) begin
      mem_ack = 1'b0; mem_rdata = 8'($urandom);
    end else if (t_act && nx <= t_len && in_mem(nx)) begin
      mem_ack   = (nx == 1 + t_w);
      mem_rdata = t_we ? 8'($urandom) : mem[t_addr];
    end else begin
      mem_ack = ($urandom_range(0, 3) == 0); mem_rdata = 8'($urandom);
    end
    #1;
    if (reset) begin
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      t_act = 0; ptr = 0; m_hit = 0; m_miss = 0;
    end else begin
      e_ready = '0; e_rsp = '0; e_lk = 0; e_fill = 0; e_mreq = 0; e_mwe = 0;
      e_lkaddr = '0; e_faddr = '0; e_maddr = '0; e_fdata = '0; e_mwdata = '0; e_rdata = '0;
      acc = -1;
      if (t_act) begin
        t_off++;
        if (t_off > t_len) t_act = 0;
      end
      if (!t_act) begin
        for (int i = 0; i < NUM_REQ; i++)
          if (acc < 0 && p_valid[(ptr + i) % NUM_REQ]) acc = (ptr + i) % NUM_REQ;
        if (acc >= 0) begin
          e_ready[acc] = 1'b1; e_lk = 1'b1; e_lkaddr = p_addr[acc];
        end
      end else begin
        if (t_off == 1 && t_we && t_hit) begin
          e_fill = 1; e_faddr = t_addr; e_fdata = t_wdata;
        end
        if (in_mem(t_off)) begin
          e_mreq = 1; e_mwe = t_we; e_maddr = t_addr; e_mwdata = t_wdata;
        end
        if (!t_we && !t_hit && t_off == 2 + t_w) begin
          e_fill = 1; e_faddr = t_addr; e_fdata = t_rdata;
        end
        if (t_off == t_len) begin
          e_rsp[t_g] = 1'b1; e_rdata = t_we ? '0 : t_rdata;
        end
      end
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("lk_valid", 32'(lk_valid), 32'(e_lk));
      if (e_lk) chk("lk_addr", 32'(lk_addr), 32'(e_lkaddr));
      chk("fill_en", 32'(fill_en), 32'(e_fill));
      if (e_fill) begin
        chk("fill_addr", 32'(fill_addr), 32'(e_faddr));
        chk("fill_data", 32'(fill_data), 32'(e_fdata));
      end
      chk("mem_req", 32'(mem_req), 32'(e_mreq));
      if (e_mreq) begin
        chk("mem_we", 32'(mem_we), 32'(e_mwe));
        chk("mem_addr", 32'(mem_addr), 32'(e_maddr));
        if (e_mwe) chk("mem_wdata", 32'(mem_wdata), 32'(e_mwdata));
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
      if (e_rsp != 0) chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
`ifdef DCACHE_CTRL_STATS_EN
      chk("hit_cnt", 32'(hit_cnt), 32'(m_hit));
      chk("miss_cnt", 32'(miss_cnt), 32'(m_miss));
`endif
      if (t_act) begin
        if (t_off == 1) begin
          if (t_hit) m_hit++; else m_miss++;
        end
        if (t_we && in_mem(t_off) && t_off == 1 + t_w) mem[t_addr] = t_wdata;
        if (t_off == t_len) ptr = (t_g + 1) % NUM_REQ;
      end
      if (acc >= 0) begin
        t_act = 1; t_off = 0; t_g = acc;
        t_we = p_we[acc]; t_addr = p_addr[acc]; t_wdata = p_wdata[acc];
        t_hit = cvalid[t_addr];
        t_w = (force_w > 0) ? force_w : $urandom_range(1, 4);
        t_rdata = t_hit ? cdata[t_addr] : mem[t_addr];
        t_len = (!t_we && t_hit) ? 2 : (!t_we ? 3 + t_w : 2 + t_w);
        p_valid[acc] = 0;
      end
    end
    // observe what the DUT actually did
    if (req_ready != 0) begin
      gidx = 0;
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) gidx = i;
      grant_log.push_back(gidx); acc_cyc = cyc;
    end
    if (mem_req) mreq_cycles++;
    if (mem_req && mem_we) last_mw_data = mem_wdata;
    if (fill_en) begin
      cvalid[fill_addr] = 1; cdata[fill_addr] = fill_data;
      last_fill_addr = fill_addr; last_fill_data = fill_data;
    end
    if (rsp_valid != 0) begin
      rsp_count++; last_rsp_lat = cyc - acc_cyc; last_rsp_data = rsp_rdata;
      for (int i = 0; i < NUM_REQ; i++) if (rsp_valid[i]) last_rsp_idx = i;
    end
    prev_lk = lk_valid; prev_lkaddr = lk_addr;
    cyc++;
  endtask

  function automatic bit busy();
    bit b = t_act;
    for (int i = 0; i < NUM_REQ; i++) b |= p_valid[i];
    return b;
  endfunction

  task automatic run_until_idle(input int max_cyc, input string tag);
    int n = 0;
    while (busy() && n < max_cyc) begin cycle(); n++; end
    if (n >= max_cyc) chk({tag, "_timeout"}, 1, 0);
  endtask

  task automatic issue(input int r, input bit we, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] wd);
    p_valid[r] = 1; p_we[r] = we; p_addr[r] = ad; p_wdata[r] = wd;
  endtask

  initial begin
    bit reraised;
    for (int i = 0; i < 512; i++) begin mem[i] = 8'($urandom); cvalid[i] = 0; cdata[i] = '0; end
    mem[9'h005] = 8'hA5;
    reset = 1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    lk_hit = 0; lk_rdata = '0; mem_ack = 0; mem_rdata = '0;
    vectors = 0; errors = 0; cyc = 0; ptr = 0; t_act = 0; prev_lk = 0; gen_en = 0;
    for (int i = 0; i < NUM_REQ; i++) begin p_valid[i] = 0; p_we[i] = 0; p_addr[i] = '0; p_wdata[i] = '0; end

    rst_req = 1; repeat (3) cycle(); rst_req = 0; cycle();
    chk("reset_outputs", 32'({req_ready, rsp_valid, lk_valid, fill_en, mem_req}), 0);

    // load miss with a 3-cycle memory
    mreq_cycles = 0; force_w = 3; issue(0, 0, 9'h005, 8'h00); run_until_idle(40, "t1");
    chk("t1_rdata", 32'(last_rsp_data), 32'h0A5);
    chk("t1_latency", last_rsp_lat, 6);
    chk("t1_mem_cycles", mreq_cycles, 3);
    chk("t1_fill_addr", 32'(last_fill_addr), 32'h005);
    chk("t1_fill_data", 32'(last_fill_data), 32'h0A5);

    // same load now hits
    mreq_cycles = 0; issue(0, 0, 9'h005, 8'h00); run_until_idle(40, "t2");
    chk("t2_rdata", 32'(last_rsp_data), 32'h0A5);
    chk("t2_latency", last_rsp_lat, 2);
    chk("t2_mem_cycles", mreq_cycles, 0);

    // store hit from requester 1
    mreq_cycles = 0; force_w = 1; cvalid[9'h185] = 1; cdata[9'h185] = 8'h77;
    issue(1, 1, 9'h185, 8'h3C); run_until_idle(40, "t3");
    chk("t3_rsp_idx", last_rsp_idx, 1);
    chk("t3_latency", last_rsp_lat, 3);
    chk("t3_fill_data", 32'(cdata[9'h185]), 32'h03C);
    chk("t3_mem_wdata", 32'(last_mw_data), 32'h03C);
    chk("t3_rdata", 32'(last_rsp_data), 0);

    // simultaneous requests out of reset: 0, 1, then 0 again
    force_w = 2; issue(0, 0, 9'h005, 8'h00); issue(1, 0, 9'h006, 8'h00);
    rst_req = 1; repeat (2) cycle(); rst_req = 0;
    grant_log.delete(); reraised = 0;
    for (int n = 0; n < 80 && !(grant_log.size() >= 3 && !busy()); n++) begin
      cycle();
      if (!reraised && grant_log.size() == 1 && !p_valid[0]) begin issue(0, 0, 9'h005, 8'h00); reraised = 1; end
    end
    chk("t4_grants", grant_log.size(), 3);
    if (grant_log.size() >= 3) begin
      chk("t4_grant0", grant_log[0], 0);
      chk("t4_grant1", grant_log[1], 1);
      chk("t4_grant2", grant_log[2], 0);
    end

    // reset while waiting on a memory read
    mreq_cycles = 0; rsp_count = 0; force_w = 4; cvalid[9'h0AA] = 0; cvalid[9'h0BB] = 0;
    issue(0, 0, 9'h0AA, 8'h00);
    for (int n = 0; n < 20 && !(t_act && t_off == 3); n++) cycle();
    rst_req = 1; cycle(); rst_req = 0; cycle();
    chk("t5_mem_req_after_reset", 32'(mem_req), 0);
    chk("t5_mreq_seen", 32'(mreq_cycles >= 2), 1);
    chk("t5_no_rsp", rsp_count, 0);

    // three hits and two misses after the reset
    force_w = 1;
    issue(0, 0, 9'h005, 8'h00); run_until_idle(40, "t6a");
    chk("t6_first_rdata", 32'(last_rsp_data), 32'h0A5);
    issue(0, 0, 9'h005, 8'h00); run_until_idle(40, "t6b");
    issue(0, 0, 9'h005, 8'h00); run_until_idle(40, "t6c");
    issue(0, 0, 9'h0AA, 8'h00); run_until_idle(40, "t6d");
    issue(0, 0, 9'h0BB, 8'h00); run_until_idle(40, "t6e");
    chk("t6_rsp_count", rsp_count, 5);
`ifdef DCACHE_CTRL_STATS_EN
    chk("t6_hit_cnt", 32'(hit_cnt), 3);
    chk("t6_miss_cnt", 32'(miss_cnt), 2);
`endif

    // randomized traffic
    force_w = 0; gen_en = 1;
    repeat (2000) cycle();
    gen_en = 0; run_until_idle(200, "drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
